// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Imported by the interface, the round-robin grant block and the top.
package regfile_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int REQ_COUNT    = 2;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request channels and the register-file write port.
// Valid/ready: a request transfers in any cycle where valid && ready; the requester holds
// addr/data stable while valid is high and not yet ready, and may drop valid to cancel.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic              init_done;

  // Requester / observer side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_write, rf_write_addr, rf_write_data, init_done
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_write, rf_write_addr, rf_write_data, init_done
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: a lone valid always wins,
// and when both are valid the requester named by ptr wins.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic [REQ_COUNT-1:0] valid,
  input  logic                 ptr,
  output logic [REQ_COUNT-1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = valid[0] && (!valid[1] || !ptr);
    grant[1] = valid[1] && (!valid[0] ||  ptr);
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: zero-fills every register after reset or clear,
// then round-robins two writeback requesters onto a registered write port.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter bit DISCARD_R0 = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  regfile_write_arbiter_if.slave  bus,
  output arb_state_t              state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  arb_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ptr_q, ptr_d;
  logic                rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [REQ_COUNT-1:0] valid;
  logic [REQ_COUNT-1:0] grant;
  logic [REQ_COUNT-1:0] ready;
  logic [REQ_COUNT-1:0] hs;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .valid (valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Grants only become readies in RUN, and a clear in RUN blocks the handshake.
  assign ready    = (state_q == RUN && !clear) ? grant : '0;
  assign hs       = ready & valid;
  assign sel_addr = hs[0] ? bus.req0_addr : bus.req1_addr;
  assign sel_data = hs[0] ? bus.req0_data : bus.req1_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    rf_write_d = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      INIT: begin
        rf_write_d = 1'b1;
        addr_d     = cnt_q;
        data_d     = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_REG) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (|hs) begin
          // After a req0 transfer req1 gets priority, and vice versa.
          ptr_d = hs[0];
          if (!(DISCARD_R0 && sel_addr == '0)) begin
            rf_write_d = 1'b1;
            addr_d     = sel_addr;
            data_d     = sel_data;
          end
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      rf_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rf_write_q <= rf_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.req0_ready    = ready[0];
  assign bus.req1_ready    = ready[1];
  assign bus.rf_write      = rf_write_q;
  assign bus.rf_write_addr = addr_q;
  assign bus.rf_write_data = data_q;
  assign bus.init_done     = (state_q == RUN);
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: zero-fill, single and alternating grants,
// r0 discard, clear in RUN and asynchronous reset in the middle of the fill.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  logic       clk;
  logic       reset;
  logic       clear;
  arb_state_t state_dbg;

  int n_checks;
  int n_pass;

  logic [63:0] exp_q[$];

  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_write_arbiter #(
    .ADDR_W     (5),
    .DATA_W     (32),
    .NUM_REGS   (32),
    .DISCARD_R0 (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we"},   64'(bus.rf_write), 64'd1);
    check({tag, ".addr"}, 64'(bus.rf_write_addr), 64'(a));
    check({tag, ".data"}, 64'(bus.rf_write_data), 64'(d));
  endtask

  // Walks a full 32-write zero-fill starting at the current negedge in INIT.
  task automatic check_fill(input string tag);
    for (int i = 0; i < 32; i++) begin
      check({tag, ".rdy0"}, 64'(bus.req0_ready), 64'd0);
      check({tag, ".rdy1"}, 64'(bus.req1_ready), 64'd0);
      step();
      check_write(tag, 5'(i), 32'd0);
      check({tag, ".done"}, 64'(bus.init_done), (i == 31) ? 64'd1 : 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  a0_list[4];
    logic [4:0]  a1_list[4];
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [63:0] ev;
    int i0, i1;

    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    clear    = 1'b0;
    idle();
    step();
    step();

    // Reset state.
    check("rst.we",   64'(bus.rf_write), 64'd0);
    check("rst.addr", 64'(bus.rf_write_addr), 64'd0);
    check("rst.data", 64'(bus.rf_write_data), 64'd0);
    check("rst.done", 64'(bus.init_done), 64'd0);
    check("rst.state", 64'(state_dbg), 64'(INIT));

    // 1: zero-fill with both requesters waiting.
    reset = 1'b0;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    check_fill("fill");
    idle();
    check("fill.rdy_idle", 64'(bus.req0_ready | bus.req1_ready), 64'd0);
    step();
    check("fill.end_we", 64'(bus.rf_write), 64'd0);

    // 2: req0 alone.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("solo0.rdy0", 64'(bus.req0_ready), 64'd1);
    check("solo0.rdy1", 64'(bus.req1_ready), 64'd0);
    step();
    idle();
    check_write("solo0", 5'd5, 32'hDEADBEEF);
    step();
    check("solo0.idle_we", 64'(bus.rf_write), 64'd0);
    check("solo0.hold_addr", 64'(bus.rf_write_addr), 64'd5);

    // req1 alone, which also hands priority back to req0.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h7);
    check("solo1.rdy0", 64'(bus.req0_ready), 64'd0);
    check("solo1.rdy1", 64'(bus.req1_ready), 64'd1);
    step();
    idle();
    check_write("solo1", 5'd20, 32'h7);

    // 3: both valid continuously; grants alternate starting with req0.
    a0_list = '{5'd1, 5'd2, 5'd3, 5'd4};
    a1_list = '{5'd9, 5'd10, 5'd11, 5'd12};
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, a0_list[i0], 32'hA000_0000 | 32'(a0_list[i0]),
            1'b1, a1_list[i1], 32'hB000_0000 | 32'(a1_list[i1]));
      check("alt.rdy0", 64'(bus.req0_ready), (c % 2 == 0) ? 64'd1 : 64'd0);
      check("alt.rdy1", 64'(bus.req1_ready), (c % 2 == 1) ? 64'd1 : 64'd0);
      if (c % 2 == 0) begin
        exp_q.push_back({27'd0, a0_list[i0], 32'hA000_0000 | 32'(a0_list[i0])});
        i0++;
      end else begin
        exp_q.push_back({27'd0, a1_list[i1], 32'hB000_0000 | 32'(a1_list[i1])});
        i1++;
      end
      step();
      ev = exp_q.pop_front();
      ea = ev[36:32];
      ed = ev[31:0];
      check_write("alt", ea, ed);
    end
    idle();
    check("alt.q_empty", 64'(exp_q.size()), 64'd0);

    // 4: req1 to address 0 is acknowledged but not written; pointer still rotates.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    check("r0.rdy1", 64'(bus.req1_ready), 64'd1);
    step();
    check("r0.we", 64'(bus.rf_write), 64'd0);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
    check("r0.next_rdy0", 64'(bus.req0_ready), 64'd1);
    check("r0.next_rdy1", 64'(bus.req1_ready), 64'd0);
    step();
    idle();
    check_write("r0.next", 5'd6, 32'h66);

    // 5: clear in RUN while req0 waits.
    drive(1'b1, 5'd8, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0);
    clear = 1'b1;
    #1;
    check("clr.rdy0", 64'(bus.req0_ready), 64'd0);
    check("clr.done_before", 64'(bus.init_done), 64'd1);
    step();
    clear = 1'b0;
    check("clr.done_after", 64'(bus.init_done), 64'd0);
    check("clr.we", 64'(bus.rf_write), 64'd0);
    check_fill("clrfill");
    check("clr.rdy0_run", 64'(bus.req0_ready), 64'd1);
    step();
    idle();
    check_write("clr.accept", 5'd8, 32'hCAFE_F00D);

    // 6: asynchronous reset mid-fill, when the counter has reached 17.
    reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check_write("mid.before", 5'd16, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid.we",    64'(bus.rf_write), 64'd0);
    check("mid.addr",  64'(bus.rf_write_addr), 64'd0);
    check("mid.data",  64'(bus.rf_write_data), 64'd0);
    check("mid.done",  64'(bus.init_done), 64'd0);
    check("mid.state", 64'(state_dbg), 64'(INIT));
    @(negedge clk);
    reset = 1'b0;
    check_fill("refill");
    step();
    check("refill.end_we", 64'(bus.rf_write), 64'd0);
    check("refill.state", 64'(state_dbg), 64'(RUN));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- After every reset or soft clear, sequences a zero-fill of all registers, because the register file itself has no reset.
- Then shares the write port between two writeback requesters (req0, e.g. ALU writeback; req1, e.g. load writeback) using round-robin arbitration over valid/ready handshakes.
- Outputs are registered and drive the register file's write, write_addr and write_data inputs directly.

Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- NUM_REGS, 32: registers cleared by the init sequence; must equal 2**ADDR_W.
- DISCARD_R0, 1: when 1, an accepted write to address 0 is acknowledged but not forwarded to the register file.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous request to re-run the zero-fill.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req1_valid  in  1  requester 1 has a write pending.
- req1_ready  out  1  requester 1 write accepted this cycle.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- rf_write  out  1  register file write enable.
- rf_write_addr  out  ADDR_W  register file write address.
- rf_write_data  out  DATA_W  register file write data.
- init_done  out  1  high while in RUN.

Behaviour:
- States: INIT, RUN. Encoding lives in the shared package.
- Reset (asynchronous, any time, including mid-INIT or mid-transfer):
  - state=INIT, init counter=0, rr pointer=0 (req0 has priority).
  - rf_write=0, rf_write_addr=0, rf_write_data=0, init_done=0.
  - In-flight transfers are lost; the zero-fill restarts from register 0.
- INIT:
  - Each cycle, the registered outputs for the next cycle are rf_write=1, rf_write_addr=counter, rf_write_data=0.
  - Counter increments each cycle. After counter=NUM_REGS-1 is issued, next state is RUN.
  - This gives exactly NUM_REGS consecutive write cycles, addresses 0..NUM_REGS-1 in order.
  - req0_ready=req1_ready=0 throughout INIT. clear is ignored in INIT.
  - The fill writes address 0 regardless of DISCARD_R0.
- RUN:
  - init_done=1.
  - Grant is combinational from the valids and the rr pointer:
    - Only one valid: that requester is granted.
    - Both valid: the requester named by the pointer is granted.
  - reqN_ready=grant_N, so at most one ready is high in any cycle.
  - Handshake occurs when reqN_valid && reqN_ready.
  - Requesters must hold valid, addr and data stable until ready. Dropping valid before ready is legal and cancels the request.
  - On a handshake, the pointer moves to the other requester. With no handshake, the pointer holds.
- Write latency: a handshake in cycle N produces rf_write=1 with the captured addr/data in cycle N+1, so the register file commits at the rising edge ending N+1. Full throughput: one write per cycle.
- Address 0 with DISCARD_R0=1: the handshake completes normally, rf_write=0 in N+1, and the pointer still rotates.
- With no handshake in cycle N, rf_write=0 in N+1. rf_write_addr and rf_write_data hold their last values.
- clear sampled high in RUN:
  - Both readies are forced to 0 that cycle; no handshake occurs.
  - A write already registered from the previous cycle still completes.
  - Next state is INIT with counter=0; the pointer is left unchanged.
- Same-address writes on consecutive cycles land in handshake order, so the later write wins.

Decomposition:
- Package regfile_arb_pkg holds:
  - state enum {INIT, RUN};
  - ADDR_W, DATA_W and NUM_REGS defaults;
  - the REQ_COUNT=2 constant.
- One sub-module, rr_arb2: a combinational 2-way round-robin grant. Inputs are the valids and the pointer; outputs are the grants.
- Pointer, FSM, init counter and output registers stay in the top module.

Test Plan:
1. Assert reset, release; hold both valids high -> rf_write=1 for exactly 32 cycles with addr 0..31 and data 0; both readies 0 throughout; init_done rises in the cycle after addr 31 is issued.
2. In RUN, req0 alone with addr=5, data=0xDEADBEEF -> req0_ready=1 in the same cycle; next cycle rf_write=1, addr=5, data=0xDEADBEEF.
3. Both valid continuously, req0 addr 1..4, req1 addr 9..12 -> grants alternate req0, req1, req0, ...; rf_write addresses 1, 9, 2, 10, ...; never two readies in one cycle.
4. req1 writes addr 0, data 0x1234 with DISCARD_R0=1 -> req1_ready=1; next cycle rf_write=0; the following simultaneous request is granted to req0.
5. clear pulsed in RUN while req0 is valid -> req0_ready=0 that cycle; init_done falls; 32 zero writes follow; req0 is accepted afterwards.
6. Reset asserted mid-INIT at counter=17 -> outputs 0 immediately, asynchronously; after release, the fill restarts at addr 0 and runs for 32 cycles.
